axis_master_fifo: RTL

Parametrised AXI-Stream master with an internal first-word-fall-through buffer. It decouples a producer, which pushes words under a valid/ready handshake, from the downstream slave, which pulls words on `s_ready`. It replaces the fixed 8-bit, unbuffered master stage, and it can optionally emit a per-burst `m_last` marker.

---
 rtl/axis_master_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/axis_master_fifo.sv
// axis_master_fifo
// AXI-Stream master stage with a first-word-fall-through buffer between a
// producer (valid/ready push side) and a downstream slave (s_ready pull side).
// Optional feature macro: AXIS_MASTER_LAST_EN
//   defined   -> per-burst beat counter drives m_last every BURST_LEN beats
//   undefined -> no beat counter is built, m_last is tied low
// The port list is the same in both builds.
module axis_master_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_in_valid,
    input  logic [DATA_WIDTH-1:0]   m_in_data,
    output logic                    m_in_ready,
    input  logic                    s_ready,
    output logic                    m_valid,
    output logic [DATA_WIDTH-1:0]   m_s_data,
    output logic                    m_last,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Legal range: DEPTH a power of two and at least 2, BURST_LEN at least 1.
    // Pointer wrap relies on the power-of-two depth; nothing is built here.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BURST_LEN < 1) begin : g_param_guard
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic w_push;
    logic w_pop;

    // Full/empty come from the occupancy count, never from pointer compare.
    // m_in_ready is also forced low during reset so that a producer cannot
    // see a handshake in the reset cycle.
    assign m_in_ready = (r_level != LVL_W'(DEPTH)) && !rst;
    assign m_valid    = (r_level != '0);
    assign m_s_data   = r_mem[r_rd_ptr];
    assign level      = r_level;

    // A pop during reset is discarded by the reset branches below.
    assign w_push = m_in_valid && m_in_ready;
    assign w_pop  = m_valid && s_ready;

    // Storage array: written on push, no reset so it can map to plain registers/LUT RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= m_in_data;
        end
    end

    // Write and read pointers, wrapping naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: +1 on push alone, -1 on pop alone, unchanged when both happen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef AXIS_MASTER_LAST_EN
    // One bit minimum so BURST_LEN == 1 still has a legal counter width.
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0] r_beat_cnt;
    logic             w_last_beat;

    assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
    assign m_last      = m_valid && w_last_beat;

    // Beat position within the current burst; wraps on the pop of the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign m_last = 1'b0;
`endif

endmodule
